// File: rtl/cam_pkg.sv
// cam_pkg: shared types, register map and helpers for the cam_scan dstream CAM slave.
package cam_pkg;

    typedef enum logic {PH_A, PH_D} dstream_phase_e;
    typedef enum logic [1:0] {OFF, INDEX, FIRST, COUNT} cam_mode_e;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} cam_state_e;

    localparam logic [23:0] CTRL_ADDR     = 24'h001000;
    localparam logic [23:0] VALID_ADDR    = 24'h001004;
    localparam logic [23:0] SEARCH_ADDR   = 24'h001008;
    localparam logic [23:0] RESULT_ADDR   = 24'h00100C;
    localparam logic [23:0] STATUS_ADDR   = 24'h001010;
    localparam logic [23:0] MASK_ADDR     = 24'h001014;
    localparam logic [23:0] MEM_BASE_ADDR = 24'h002000;
    localparam logic [23:0] MEM_ADDR_MASK = 24'hFFFF00;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/cam_scan_lanes.sv
// cam_scan_lanes: combinational compare of one scan slice of LANES entries.
module cam_scan_lanes
    import cam_pkg::*;
#(
    parameter int LANES = 2,
    parameter int WIDTH = 32,
    localparam int OW = LANES > 1 ? $clog2(LANES) : 1,
    localparam int CW = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0][WIDTH-1:0] entries,
    input  logic [LANES-1:0]            valid,
    input  logic [WIDTH-1:0]            search,
    input  logic [WIDTH-1:0]            mask,
    output logic [OW-1:0]               hit_off,
    output logic                        any_hit,
    output logic [CW-1:0]               hit_cnt
);

    // Walk downwards so the last assignment leaves the lowest hitting lane.
    always_comb begin
        hit_off = '0;
        any_hit = 1'b0;
        hit_cnt = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (valid[i] && ((entries[i] ^ search) & mask) == '0) begin
                hit_off = OW'(i);
                any_hit = 1'b1;
                hit_cnt = hit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cam_scan.sv
// cam_scan: dstream CAM slave with multi-cycle LANES-wide scan search.
// Optional MASK register at 0x1014 enabled by defining CAM_MASK_EN.
module cam_scan
    import cam_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_master,
    input  logic        d_valid,
    output logic [31:0] d_slave,
    output logic        search_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int CW = $clog2(LANES + 1);

    dstream_phase_e phase;
    cam_state_e     state, state_nxt;
    cam_mode_e      mode;

    logic [23:0]      addr_q;
    logic             wr_q;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] search, cmp_mask;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [31:0]      result, mask_rd;
    logic             hit, multi, err, busy;
    logic [7:0]       count, acc_cnt, nxt_cnt;
    logic [AW-1:0]    ptr, acc_first, nxt_first, mem_idx;
    logic             acc_hit, nxt_hit, last;
    logic             wr_en, mem_sel, ctrl_wr, valid_wr, srch_wr, stat_wr, mem_wr, cfg_wr;

    logic [LANES-1:0][WIDTH-1:0] lane_ent;
    logic [LANES-1:0]            lane_val;
    logic [OW-1:0]               lane_off;
    logic                        lane_hit;
    logic [CW-1:0]               lane_cnt;

    assign wr_en    = d_valid && phase == PH_D && wr_q;
    assign mem_idx  = addr_q[AW+1:2];
    assign mem_sel  = (addr_q & MEM_ADDR_MASK) == MEM_BASE_ADDR && addr_q[1:0] == 2'b00 &&
                      {1'b0, addr_q[7:0]} < 9'(4 * DEPTH);
    assign ctrl_wr  = wr_en && addr_q == CTRL_ADDR;
    assign valid_wr = wr_en && addr_q == VALID_ADDR;
    assign srch_wr  = wr_en && addr_q == SEARCH_ADDR;
    assign stat_wr  = wr_en && addr_q == STATUS_ADDR;
    assign mem_wr   = wr_en && mem_sel;

`ifdef CAM_MASK_EN
    logic [WIDTH-1:0] mask;
    logic             mask_wr;
    assign mask_wr  = wr_en && addr_q == MASK_ADDR;
    assign cmp_mask = mask;
    assign mask_rd  = 32'(mask);
    assign cfg_wr   = ctrl_wr || valid_wr || mem_wr || mask_wr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask <= '1;
        else if (mask_wr && !busy) mask <= WIDTH'(d_master);
    end
`else
    assign cmp_mask = '1;
    assign mask_rd  = '0;
    assign cfg_wr   = ctrl_wr || valid_wr || mem_wr;
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_ent[i] = mem[ptr + AW'(i)];
            lane_val[i] = valid[ptr + AW'(i)];
        end
    end

    cam_scan_lanes #(.LANES(LANES), .WIDTH(WIDTH)) u_lanes (
        .entries (lane_ent),
        .valid   (lane_val),
        .search  (search),
        .mask    (cmp_mask),
        .hit_off (lane_off),
        .any_hit (lane_hit),
        .hit_cnt (lane_cnt)
    );

    // Accumulators folded with the current slice; on the final slice these are the result.
    assign last      = ptr == AW'(DEPTH - LANES);
    assign nxt_hit   = acc_hit || lane_hit;
    assign nxt_first = acc_hit ? acc_first : ptr + AW'(lane_off);
    assign nxt_cnt   = sat_add(acc_cnt, 8'(lane_cnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        busy      = state == SCAN;
        state_nxt = srch_wr && mode[1] ? SCAN :
                    state == SCAN && last ? DONE :
                    state == SCAN ? SCAN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (mem_wr && !busy) mem[mem_idx] <= WIDTH'(d_master);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= PH_A;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            mode        <= OFF;
            valid       <= '0;
            search      <= '0;
            result      <= '0;
            hit         <= 1'b0;
            multi       <= 1'b0;
            err         <= 1'b0;
            count       <= '0;
            ptr         <= '0;
            acc_hit     <= 1'b0;
            acc_first   <= '0;
            acc_cnt     <= '0;
            search_done <= 1'b0;
        end else begin
            if (d_valid) begin
                phase <= phase == PH_A ? PH_D : PH_A;
                if (phase == PH_A) begin
                    addr_q <= d_master[23:0];
                    wr_q   <= d_master[24];
                end
            end
            if (ctrl_wr && !busy) mode <= cam_mode_e'(d_master[1:0]);
            if (valid_wr && !busy) valid <= DEPTH'(d_master);
            if (mem_wr && !busy) valid[mem_idx] <= 1'b1;
            if (srch_wr) search <= WIDTH'(d_master);
            if (stat_wr) err <= 1'b0;
            else if (busy && cfg_wr) err <= 1'b1;
            search_done <= (srch_wr && mode == INDEX) || (busy && last && !srch_wr);
            if (srch_wr && mode == INDEX) result <= 32'(mem[d_master[AW-1:0]]);
            if (srch_wr) begin
                ptr       <= '0;
                acc_hit   <= 1'b0;
                acc_first <= '0;
                acc_cnt   <= '0;
            end else if (busy) begin
                ptr       <= ptr + AW'(LANES);
                acc_hit   <= nxt_hit;
                acc_first <= nxt_first;
                acc_cnt   <= nxt_cnt;
                if (last) begin
                    result <= mode == FIRST ? (nxt_hit ? 32'(nxt_first) : '1) : 32'(nxt_cnt);
                    hit    <= nxt_hit;
                    multi  <= nxt_cnt >= 8'd2;
                    count  <= nxt_cnt;
                end
            end
        end
    end

    always_comb begin
        d_slave = mem_sel                ? 32'(mem[mem_idx]) :
                  addr_q == CTRL_ADDR    ? 32'(mode) :
                  addr_q == VALID_ADDR   ? 32'(valid) :
                  addr_q == SEARCH_ADDR  ? 32'(search) :
                  addr_q == RESULT_ADDR  ? result :
                  addr_q == STATUS_ADDR  ? {16'h0, count, 4'h0, err, multi, hit, busy} :
                  addr_q == MASK_ADDR    ? mask_rd : '0;
    end

endmodule

// File: tb/tb_cam_scan.sv
// tb_cam_scan: randomized self-checking bench for cam_scan against an array-based CAM model.
module tb_cam_scan;

    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int LAT   = DEPTH / LANES + 1;

    localparam logic [23:0] A_CTRL   = 24'h001000;
    localparam logic [23:0] A_VALID  = 24'h001004;
    localparam logic [23:0] A_SEARCH = 24'h001008;
    localparam logic [23:0] A_RESULT = 24'h00100C;
    localparam logic [23:0] A_STATUS = 24'h001010;
    localparam logic [23:0] A_MASK   = 24'h001014;

    logic        clk = 1'b0, rst_n = 1'b0, d_valid = 1'b0, search_done;
    logic [31:0] d_master = '0, d_slave;

    cam_scan #(.DEPTH(DEPTH), .WIDTH(32), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_master    (d_master),
        .d_valid     (d_valid),
        .d_slave     (d_slave),
        .search_done (search_done)
    );

    always #5 clk = ~clk;

    int cyc = 0, done_cnt = 0, done_cyc = 0, n_chk = 0, n_fail = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (search_done) begin done_cnt++; done_cyc = cyc; end

    logic [31:0]      m_mem [DEPTH];
    logic [DEPTH-1:0] m_valid;
    logic [1:0]       m_mode;
    logic [31:0]      m_search, m_result, m_mask;
    logic             m_hit, m_multi, m_err;
    int               m_cnt;
    logic [31:0]      pool [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = '0; m_mode = 0; m_search = '0; m_result = '0; m_mask = '1;
        m_hit = 0; m_multi = 0; m_err = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] status_exp();
        return {16'h0, 8'(m_cnt), 4'h0, m_err, m_multi, m_hit, 1'b0};
    endfunction

    function automatic logic [31:0] mask_exp();
`ifdef CAM_MASK_EN
        return m_mask;
`else
        return 32'h0;
`endif
    endfunction

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        d_valid = 1'b1; d_master = {7'h0, 1'b1, a};
        @(posedge clk); #1;
        d_master = d;
        @(posedge clk); #1;
        d_valid = 1'b0; d_master = '0;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
        d_valid = 1'b1; d_master = {8'h0, a};
        @(posedge clk); #1;
        d = d_slave;
        @(posedge clk); #1;
        d_valid = 1'b0; d_master = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [23:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Idle-time register write, mirrored into the model.
    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        bus_write(a, d);
        if (a == A_CTRL) m_mode = d[1:0];
        else if (a == A_VALID) m_valid = d[DEPTH-1:0];
        else if (a == A_SEARCH) m_search = d;
        else if (a == A_STATUS) m_err = 0;
`ifdef CAM_MASK_EN
        else if (a == A_MASK) m_mask = d;
`endif
        else if (a >= 24'h2000 && a < 24'h2000 + 4 * DEPTH && a[1:0] == 2'b00) begin
            m_mem[(a - 24'h2000) >> 2] = d;
            m_valid[(a - 24'h2000) >> 2] = 1'b1;
        end
    endtask

    task automatic model_search(input logic [31:0] s);
        int c, f;
        c = 0; f = -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && ((m_mem[i] ^ s) & m_mask) == 0) begin
                c++;
                if (f < 0) f = i;
            end
        if (m_mode == 1) m_result = m_mem[s % DEPTH];
        if (m_mode >= 2) begin
            m_result = m_mode == 2 ? (f < 0 ? 32'hFFFF_FFFF : 32'(f)) : 32'(c);
            m_hit = c > 0; m_multi = c >= 2; m_cnt = c > 255 ? 255 : c;
        end
    endtask

    task automatic search_chk(input string tag, input logic [31:0] s);
        int d0, w;
        d0 = done_cnt;
        bus_write(A_SEARCH, s);
        w = cyc - 1;
        m_search = s;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check({tag, "_pulses"}, done_cnt - d0, m_mode == 0 ? 0 : 1);
        if (m_mode != 0) check({tag, "_latency"}, done_cyc - w, m_mode == 1 ? 1 : LAT);
        model_search(s);
        rd_chk({tag, "_result"}, A_RESULT, m_result);
        rd_chk({tag, "_status"}, A_STATUS, status_exp());
    endtask

    initial begin
        int d0, w;
        logic [31:0] s;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset_done", search_done, 0);
        rd_chk("rst_ctrl", A_CTRL, 0);
        rd_chk("rst_valid", A_VALID, 0);
        rd_chk("rst_search", A_SEARCH, 0);
        rd_chk("rst_result", A_RESULT, 0);
        rd_chk("rst_status", A_STATUS, 0);
        rd_chk("rst_mask", A_MASK, mask_exp());
        rd_chk("unmapped", 24'h003000, 0);

        wr(24'h2008, 32'hA5);
        rd_chk("mem_valid", A_VALID, 32'h4);
        rd_chk("mem_read", 24'h2008, 32'hA5);

        wr(24'h200C, 32'h55);
        wr(A_CTRL, 1);
        search_chk("index", 3);

        wr(24'h2004, 32'h77);
        wr(24'h2014, 32'h77);
        wr(A_CTRL, 2);
        search_chk("first_hit", 32'h77);
        wr(A_CTRL, 3);
        search_chk("count_miss", 32'h99);
        wr(A_CTRL, 2);
        search_chk("first_miss", 32'h99);

        // Writes landing while the scan runs must be dropped and flag err.
        d0 = done_cnt;
        bus_write(A_SEARCH, 32'h77);
        m_search = 32'h77;
        bus_write(24'h2000, 32'h77);
        bus_write(A_CTRL, 3);
        m_err = 1;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("busy_pulses", done_cnt - d0, 1);
        model_search(32'h77);
        rd_chk("busy_result", A_RESULT, m_result);
        rd_chk("busy_valid", A_VALID, 32'(m_valid));
        rd_chk("busy_ctrl", A_CTRL, 2);
        rd_chk("busy_status", A_STATUS, status_exp());

        d0 = done_cnt;
        bus_write(A_SEARCH, 32'h77);
        bus_write(A_SEARCH, 32'h55);
        w = cyc - 1;
        m_search = 32'h55;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("restart_pulses", done_cnt - d0, 1);
        check("restart_latency", done_cyc - w, LAT);
        model_search(32'h55);
        rd_chk("restart_result", A_RESULT, m_result);
        wr(A_STATUS, 0);
        rd_chk("err_clear", A_STATUS, status_exp());

        for (int i = 0; i < DEPTH; i++) wr(24'h2000 + 24'(4 * i), pool[$urandom_range(0, 2)]);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: wr(24'h2000 + 24'(4 * $urandom_range(0, DEPTH - 1)), pool[$urandom_range(0, 2)]);
                1: wr(A_VALID, $urandom_range(0, 255));
                2: wr(A_CTRL, $urandom_range(0, 3));
                default: begin
                    s = m_mode == 1 ? 32'($urandom_range(0, DEPTH - 1)) : pool[$urandom_range(0, 3)];
                    search_chk("rand", s);
                    rd_chk("rand_search", A_SEARCH, m_search);
                end
            endcase
        end

        wr(A_CTRL, 2);
        d0 = done_cnt;
        bus_write(A_SEARCH, 32'h11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("rst_mid_pulses", done_cnt - d0, 0);
        rd_chk("rst_mid_status", A_STATUS, 0);
        rd_chk("rst_mid_result", A_RESULT, 0);
        rd_chk("rst_mid_ctrl", A_CTRL, 0);
        rd_chk("rst_mid_valid", A_VALID, 0);

`ifdef CAM_MASK_EN
        wr(A_MASK, 32'hF0);
        rd_chk("mask_read", A_MASK, 32'hF0);
        wr(24'h2000, 32'h12);
        wr(A_CTRL, 2);
        search_chk("mask_hit", 32'h1F);
        check("mask_result", m_result, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
